// File: rtl/button_pkg.sv
// Shared types and elaboration-time helpers for the push-button debouncer.
package button_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE_PRESS,
    ST_HELD_DELAY,
    ST_HELD_REPEAT,
    ST_SETTLE_RELEASE
  } state_t;

  // Milliseconds to clock cycles; never returns 0 so "load N-1" stays valid.
  function automatic logic [CNT_W-1:0] ms_to_cycles(input logic [31:0] freq,
                                                     input logic [31:0] ms);
    logic [CNT_W-1:0] cycles;
    cycles = freq / 32'd1000 * ms;
    return (cycles == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : cycles;
  endfunction

  function automatic logic [CNT_W-1:0] hz_to_cycles(input logic [31:0] freq,
                                                     input logic [31:0] hz);
    logic [CNT_W-1:0] cycles;
    cycles = (hz == 32'd0) ? '0 : freq / hz;
    return (cycles == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : cycles;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sync_reg <= {2{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/button_debounce.sv
// Debounces one raw button pin into a held level, press/release pulses and
// an auto-repeating step pulse.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 12000000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_HZ  = 4,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic btn_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic step_o
);

  localparam logic             INACTIVE = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEB_CNT  = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam logic [CNT_W-1:0] DLY_CNT  = ms_to_cycles(CLK_FREQ, REPEAT_DELAY_MS);
  localparam logic [CNT_W-1:0] PER_CNT  = hz_to_cycles(CLK_FREQ, REPEAT_RATE_HZ);
  localparam logic [CNT_W-1:0] DEB_LOAD = DEB_CNT - CNT_ONE;
  localparam logic [CNT_W-1:0] DLY_LOAD = DLY_CNT - CNT_ONE;
  localparam logic [CNT_W-1:0] PER_LOAD = PER_CNT - CNT_ONE;

  logic btn_sync;
  logic s;

  state_t           state_reg,   state_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic             pressed_reg, pressed_next;
  logic             press_reg,   press_next;
  logic             release_reg, release_next;
  logic             step_reg,    step_next;

  sync_2ff #(
    .RESET_VAL(INACTIVE)
  ) u_sync (
    .CLK_IN(CLK_IN),
    .RST_N (RST_N),
    .d     (btn_i),
    .q     (btn_sync)
  );

  // Normalise to active-high so the FSM never cares about pin polarity.
  assign s = btn_sync ^ INACTIVE;

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      pressed_reg <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      step_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pressed_reg <= pressed_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      step_reg    <= step_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pressed_next = pressed_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    step_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (s) begin
          state_next = ST_SETTLE_PRESS;
          cnt_next   = DEB_LOAD;
        end
      end
      ST_SETTLE_PRESS: begin
        if (!s) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == '0) begin
          pressed_next = 1'b1;
          press_next   = 1'b1;
          step_next    = 1'b1;
          state_next   = ST_HELD_DELAY;
          cnt_next     = DLY_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      ST_HELD_DELAY: begin
        if (!s) begin
          state_next = ST_SETTLE_RELEASE;
          cnt_next   = DEB_LOAD;
        end else if (cnt_reg == '0) begin
          // Without auto-repeat the counter simply parks at zero.
          if (REPEAT_EN) begin
            step_next  = 1'b1;
            state_next = ST_HELD_REPEAT;
            cnt_next   = PER_LOAD;
          end
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      ST_HELD_REPEAT: begin
        // Release start wins over a coincident repeat tick.
        if (!s) begin
          state_next = ST_SETTLE_RELEASE;
          cnt_next   = DEB_LOAD;
        end else if (cnt_reg == '0) begin
          step_next = 1'b1;
          cnt_next  = PER_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      ST_SETTLE_RELEASE: begin
        if (s) begin
          state_next = REPEAT_EN ? ST_HELD_REPEAT : ST_HELD_DELAY;
          cnt_next   = PER_LOAD;
        end else if (cnt_reg == '0) begin
          pressed_next = 1'b0;
          release_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        cnt_next     = '0;
        pressed_next = 1'b0;
      end
    endcase
  end

  assign pressed_o = pressed_reg;
  assign press_o   = press_reg;
  assign release_o = release_reg;
  assign step_o    = step_reg;

endmodule

// File: tb/tb_button_debounce.sv
// Randomised bench for button_debounce: two instances (repeat on/off) against a
// timestamp-based model of the debounce and auto-repeat rules.
module tb_button_debounce;

  localparam int DEB = 1000 / 1000 * 4;
  localparam int DLY = 1000 / 1000 * 20;
  localparam int PER = 1000 / 100;

  logic       CLK_IN = 1'b0;
  logic       RST_N;
  logic       btn_i;
  logic [1:0] pressed_w, press_w, release_w, step_w;

  int tests_run    = 0;
  int tests_failed = 0;

  button_debounce #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(20),
    .REPEAT_RATE_HZ(100), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
  ) u_dut_rep (
    .CLK_IN   (CLK_IN),
    .RST_N    (RST_N),
    .btn_i    (btn_i),
    .pressed_o(pressed_w[0]),
    .press_o  (press_w[0]),
    .release_o(release_w[0]),
    .step_o   (step_w[0])
  );

  button_debounce #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(20),
    .REPEAT_RATE_HZ(100), .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)
  ) u_dut_norep (
    .CLK_IN   (CLK_IN),
    .RST_N    (RST_N),
    .btn_i    (btn_i),
    .pressed_o(pressed_w[1]),
    .press_o  (press_w[1]),
    .release_o(release_w[1]),
    .step_o   (step_w[1])
  );

  always #5 CLK_IN = ~CLK_IN;

  // Model: pin history for the synchroniser delay, run lengths, step timestamps.
  logic b1, b2;
  int   cyc;
  bit   m_pressed[2];
  bit   m_press[2], m_rel[2], m_step[2];
  int   ones_run[2], zeros_run[2], next_step[2];
  int   n_press[2], n_rel[2], n_step[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    b1  = 1'b1;
    b2  = 1'b1;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      m_pressed[i] = 1'b0;
      m_press[i]   = 1'b0;
      m_rel[i]     = 1'b0;
      m_step[i]    = 1'b0;
      ones_run[i]  = 0;
      zeros_run[i] = 0;
      next_step[i] = 0;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      n_press[i] = 0;
      n_rel[i]   = 0;
      n_step[i]  = 0;
    end
  endtask

  task automatic model_step();
    bit s;
    bit prev_zero;
    s   = ~b2;
    b2  = b1;
    b1  = btn_i;
    for (int i = 0; i < 2; i++) begin
      m_press[i] = 1'b0;
      m_rel[i]   = 1'b0;
      m_step[i]  = 1'b0;
      prev_zero  = (zeros_run[i] > 0);
      if (s) begin
        ones_run[i]++;
        zeros_run[i] = 0;
      end else begin
        zeros_run[i]++;
        ones_run[i] = 0;
      end
      if (!m_pressed[i]) begin
        if (ones_run[i] >= DEB + 1) begin
          m_pressed[i] = 1'b1;
          m_press[i]   = 1'b1;
          m_step[i]    = 1'b1;
          next_step[i] = cyc + DLY;
        end
      end else if (!s) begin
        if (zeros_run[i] >= DEB + 1) begin
          m_pressed[i] = 1'b0;
          m_rel[i]     = 1'b1;
        end
      end else if (prev_zero) begin
        next_step[i] = cyc + PER;
      end else if (i == 0 && cyc == next_step[i]) begin
        m_step[i]    = 1'b1;
        next_step[i] = cyc + PER;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    #1;
    model_step();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pressed[%0d]", i), 32'(pressed_w[i]), 32'(m_pressed[i]));
      check($sformatf("press[%0d]", i),   32'(press_w[i]),   32'(m_press[i]));
      check($sformatf("release[%0d]", i), 32'(release_w[i]), 32'(m_rel[i]));
      check($sformatf("step[%0d]", i),    32'(step_w[i]),    32'(m_step[i]));
      n_press[i] += int'(press_w[i]);
      n_rel[i]   += int'(release_w[i]);
      n_step[i]  += int'(step_w[i]);
      if (m_press[i]) $display("[TB] cyc %0d inst %0d press", cyc, i);
      if (m_rel[i])   $display("[TB] cyc %0d inst %0d release", cyc, i);
    end
    cyc++;
  endtask

  task automatic do_reset(input int cycles);
    RST_N = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_pressed[%0d]", i), 32'(pressed_w[i]), 32'd0);
      check($sformatf("rst_press[%0d]", i),   32'(press_w[i]),   32'd0);
      check($sformatf("rst_release[%0d]", i), 32'(release_w[i]), 32'd0);
      check($sformatf("rst_step[%0d]", i),    32'(step_w[i]),    32'd0);
    end
    $display("[TB] reset for %0d cycles", cycles);
    model_reset();
    repeat (cycles) @(posedge CLK_IN);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b1;
    btn_i = 1'b1;
    model_reset();
    clear_counts();
    #2;
    do_reset(3);
    repeat (4) tick();

    // Short glitch must not qualify.
    clear_counts();
    btn_i = 1'b0;
    repeat (3) tick();
    btn_i = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("glitch_press[%0d]", i), 32'(n_press[i]), 32'd0);
      check($sformatf("glitch_step[%0d]", i),  32'(n_step[i]),  32'd0);
    end

    // Clean press held 61 edges: repeat steps at 6,26,36,46,56.
    clear_counts();
    btn_i = 1'b0;
    repeat (61) tick();
    check("hold_press[0]", 32'(n_press[0]), 32'd1);
    check("hold_step[0]",  32'(n_step[0]),  32'd5);
    check("hold_press[1]", 32'(n_press[1]), 32'd1);
    check("hold_step[1]",  32'(n_step[1]),  32'd1);

    // Bouncy release: one release, no stray steps.
    clear_counts();
    btn_i = 1'b1; repeat (2) tick();
    btn_i = 1'b0; repeat (2) tick();
    btn_i = 1'b1; repeat (2) tick();
    btn_i = 1'b0; repeat (2) tick();
    btn_i = 1'b1; repeat (14) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("bounce_release[%0d]", i), 32'(n_rel[i]),  32'd1);
      check($sformatf("bounce_step[%0d]", i),    32'(n_step[i]), 32'd0);
    end

    // Reset mid-hold, button still held afterwards.
    btn_i = 1'b0;
    repeat (31) tick();
    do_reset(2);
    clear_counts();
    repeat (12) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rehold_press[%0d]", i),   32'(n_press[i]), 32'd1);
      check($sformatf("rehold_release[%0d]", i), 32'(n_rel[i]),   32'd0);
    end
    btn_i = 1'b1;
    repeat (12) tick();

    // Random bouncing, holds and occasional resets.
    for (int seg = 0; seg < 250; seg++) begin
      int dur;
      if ($urandom_range(0, 39) == 0) do_reset(int'($urandom_range(1, 3)));
      btn_i = ~btn_i;
      if ($urandom_range(0, 3) == 0) dur = int'($urandom_range(DEB, 45));
      else dur = int'($urandom_range(1, DEB + 2));
      repeat (dur) tick();
    end
    btn_i = 1'b1;
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
